// File: rtl/vslc_pkg.sv
// ============================================================================
// Module      : vslc_pkg
// Description : Shared constants, FSM encoding and helpers for the EEPROM
//               prefetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vslc_pkg;

    localparam logic [7:0] EEPROM_READ_COMMAND = 8'h03;

    localparam int DEFAULT_SCK_HALF = 4;
    localparam int DEFAULT_CS_GAP   = 2;
    localparam int DEFAULT_DEPTH    = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CS_HIGH = 3'd1,
        ST_CMD     = 3'd2,
        ST_ADDR    = 3'd3,
        ST_READ    = 3'd4,
        ST_STALL   = 3'd5
    } state_e;

    // Chip select is asserted from the first command bit until the stream is aborted.
    function automatic logic cs_active(input state_e s);
        return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_READ) || (s == ST_STALL);
    endfunction

    function automatic logic sck_running(input state_e s);
        return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_READ);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vslc_byte_fifo.sv
// ============================================================================
// Module      : vslc_byte_fifo
// Description : Small synchronous FIFO with flush; head is zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vslc_byte_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_i) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rptr_q] : '0;
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/vslc_eeprom_prefetch.sv
// ============================================================================
// Module      : vslc_eeprom_prefetch
// Description : SPI mode-0 READ sequencer for a 25xx EEPROM feeding a byte
//               prefetch FIFO with a valid/ready consumer interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vslc_eeprom_prefetch
    import vslc_pkg::*;
#(
    parameter int SCK_HALF = DEFAULT_SCK_HALF,
    parameter int CS_GAP   = DEFAULT_CS_GAP,
    parameter int DEPTH    = DEFAULT_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    input  logic [7:0] start_addr,
    output logic       busy,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [7:0] out_addr,
    input  logic       out_ready,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic       spi_copi,
    input  logic       spi_cipo
);

    localparam int PW = $clog2(2 * SCK_HALF);
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(2 * SCK_HALF - 1);
    localparam logic [PW-1:0] PH_HIGH = PW'(SCK_HALF);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   ph_q, ph_d;
    logic [2:0]      bit_q, bit_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [7:0]      sh_out_q, sh_out_d;
    logic [6:0]      sh_in_q, sh_in_d;
    logic [7:0]      addr_q, addr_d;
    logic            push_valid_q, push_valid_d;
    logic [15:0]     push_data_q, push_data_d;
    logic            cs_n_q, cs_n_d;
    logic            sck_q, sck_d;
    logic            copi_q, copi_d;
    logic            sync1_q, sync2_q;

    logic                   w_flush;
    logic                   w_push;
    logic                   w_pop;
    logic [15:0]            w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic [7:0]             w_used;
    logic                   w_room_next;
    logic                   w_room_stall;
    logic                   w_ph_last;
    logic                   w_bit_last;

    vslc_byte_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (w_flush),
        .push_i      (w_push),
        .push_data_i (push_data_q),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count)
    );

    assign out_valid = (w_count != '0);
    assign out_addr  = w_head[15:8];
    assign out_data  = w_head[7:0];
    assign w_pop     = out_valid & out_ready;
    // An abort discards the byte waiting to enter the FIFO.
    assign w_push    = push_valid_q & ~start_valid;
    assign w_flush   = start_valid;

    // Occupancy plus the completed byte still in the push register; a pop this
    // cycle frees one slot in time for the decision.
    assign w_used       = 8'(w_count) + 8'(push_valid_q);
    assign w_room_next  = (w_used + 8'd1) < (8'(DEPTH) + 8'(w_pop));
    assign w_room_stall = w_used < (8'(DEPTH) + 8'(w_pop));

    assign w_ph_last  = (ph_q == PH_LAST);
    assign w_bit_last = (bit_q == 3'd7);

    assign busy     = (state_q != ST_IDLE);
    assign spi_cs_n = cs_n_q;
    assign spi_sck  = sck_q;
    assign spi_copi = copi_q;

    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        bit_d        = bit_q;
        gap_d        = gap_q;
        sh_out_d     = sh_out_q;
        sh_in_d      = sh_in_q;
        addr_d       = addr_q;
        push_valid_d = 1'b0;
        push_data_d  = push_data_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_CS_HIGH: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GAP_LAST) begin
                    state_d  = ST_CMD;
                    ph_d     = '0;
                    bit_d    = 3'd0;
                    sh_out_d = EEPROM_READ_COMMAND;
                end
            end
            ST_CMD, ST_ADDR: begin
                ph_d = w_ph_last ? '0 : ph_q + PW'(1);
                if (w_ph_last) begin
                    bit_d    = bit_q + 3'd1;
                    sh_out_d = {sh_out_q[6:0], 1'b0};
                    if (w_bit_last) begin
                        if (state_q == ST_CMD) begin
                            state_d  = ST_ADDR;
                            sh_out_d = addr_q;
                        end else begin
                            state_d  = ST_READ;
                            sh_out_d = 8'h00;
                        end
                    end
                end
            end
            ST_READ: begin
                ph_d = w_ph_last ? '0 : ph_q + PW'(1);
                if (w_ph_last) begin
                    bit_d   = bit_q + 3'd1;
                    sh_in_d = {sh_in_q[5:0], sync2_q};
                    if (w_bit_last) begin
                        push_valid_d = 1'b1;
                        push_data_d  = {addr_q, sh_in_q, sync2_q};
                        addr_d       = addr_q + 8'd1;
                        if (!w_room_next) begin
                            state_d = ST_STALL;
                        end
                    end
                end
            end
            ST_STALL: begin
                if (w_room_stall) begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_valid) begin
            state_d      = ST_CS_HIGH;
            gap_d        = '0;
            addr_d       = start_addr;
            push_valid_d = 1'b0;
        end

        // Pins are registered from next-state values so they stay glitch-free
        // and line up with the state they belong to.
        cs_n_d = ~cs_active(state_d);
        sck_d  = sck_running(state_d) && (ph_d >= PH_HIGH);
        copi_d = ((state_d == ST_CMD) || (state_d == ST_ADDR)) ? sh_out_d[7] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ph_q         <= '0;
            bit_q        <= 3'd0;
            gap_q        <= '0;
            sh_out_q     <= 8'h00;
            sh_in_q      <= 7'h00;
            addr_q       <= 8'h00;
            push_valid_q <= 1'b0;
            push_data_q  <= 16'h0000;
            cs_n_q       <= 1'b1;
            sck_q        <= 1'b0;
            copi_q       <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            bit_q        <= bit_d;
            gap_q        <= gap_d;
            sh_out_q     <= sh_out_d;
            sh_in_q      <= sh_in_d;
            addr_q       <= addr_d;
            push_valid_q <= push_valid_d;
            push_data_q  <= push_data_d;
            cs_n_q       <= cs_n_d;
            sck_q        <= sck_d;
            copi_q       <= copi_d;
            sync1_q      <= spi_cipo;
            sync2_q      <= sync1_q;
        end
    end

endmodule

`default_nettype wire
